// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, loader state encoding and instruction constants.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} loaderState_t;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: word-addressed instruction RAM, one write port, one registered read port.
module imem_ram
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a handshaked byte stream into instruction words and serves fetches.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int CNT_W = $clog2(DEPTH_WORDS) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  input  logic             load_end,
  output logic             loading,
  output logic             load_done,
  output logic [CNT_W-1:0] word_count,
  output logic             overflow,
  input  logic [XLEN-1:0]  readAddress,
  output logic [XLEN-1:0]  instruction,
  output logic             fimDoArquivo
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int IW = $clog2(INSTR_BYTES);
  loaderState_t state;
  logic [IW-1:0] byteIdx, nextIdx;
  logic [XLEN-1:0] packBuf, nextBuf, ramQ;
  logic [AW-1:0] widx;
  logic full, accept, lastByte, flush, we, hit, hitQ;
  logic [1:0] unusedLow;
  assign unusedLow = readAddress[1:0];
  assign full = word_count == CNT_W'(DEPTH_WORDS);
  assign byte_ready = state == LOAD && !full;
  assign accept = byte_valid && byte_ready;
  assign nextBuf = accept ? packBuf | (XLEN'(byte_data) << {byteIdx, 3'b000}) : packBuf;
  assign nextIdx = byteIdx + IW'(accept);
  assign lastByte = accept && byteIdx == IW'(INSTR_BYTES - 1);
  // A flush only pads a word that actually holds bytes after this cycle's accept.
  assign flush = load_end && nextIdx != '0;
  assign we = state == LOAD && (lastByte || (flush && !full));
  assign widx = readAddress[AW+1:2];
  assign hit = state == DONE && {1'b0, widx} < word_count && readAddress[XLEN-1:AW+2] == '0;
  assign instruction = hitQ ? ramQ : '0;
  assign fimDoArquivo = !hitQ;
  imem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(word_count[AW-1:0]),
    .wdata(nextBuf),
    .raddr(widx),
    .rdata(ramQ)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      loading    <= 1'b0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
      byteIdx    <= '0;
      packBuf    <= '0;
      hitQ       <= 1'b0;
    end else begin
      hitQ <= hit;
      if (state != LOAD && load_start) begin
        state      <= LOAD;
        loading    <= 1'b1;
        load_done  <= 1'b0;
        overflow   <= 1'b0;
        word_count <= '0;
        byteIdx    <= '0;
        packBuf    <= '0;
      end else if (state == LOAD) begin
        if (byte_valid && full) overflow <= 1'b1;
        if (we) word_count <= word_count + CNT_W'(1);
        if (load_end) begin
          if (flush && full) overflow <= 1'b1;
          state     <= DONE;
          loading   <= 1'b0;
          load_done <= 1'b1;
          byteIdx   <= '0;
          packBuf   <= '0;
        end else begin
          byteIdx <= nextIdx;
          packBuf <= lastByte ? '0 : nextBuf;
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table vectors, corner sequences and random traffic against a byte-queue model.
module tb_imem_loader;
  localparam int D = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic load_start = 0, byte_valid = 0, load_end = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, loading, load_done, overflow, fimDoArquivo;
  logic [2:0] word_count;
  logic [31:0] readAddress = 0, instruction;
  int checks = 0, errors = 0;
  int mst = 0;
  byte unsigned q[$];
  bit mov = 0, hitE = 0;
  logic [31:0] insE = 0;

  imem_loader #(.DEPTH_WORDS(D)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .load_end(load_end),
    .loading(loading), .load_done(load_done), .word_count(word_count),
    .overflow(overflow), .readAddress(readAddress), .instruction(instruction),
    .fimDoArquivo(fimDoArquivo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wcount();
    return mst == 2 ? (q.size() + 3) / 4 : q.size() / 4;
  endfunction

  function automatic logic [31:0] wordAt(input int i);
    logic [31:0] w = 0;
    for (int b = 0; b < 4; b++)
      if (4 * i + b < q.size()) w[8*b +: 8] = q[4*i+b];
    return w;
  endfunction

  task automatic checkAll();
    chk("loading", loading, mst == 1);
    chk("load_done", load_done, mst == 2);
    chk("word_count", word_count, wcount());
    chk("overflow", overflow, mov);
    chk("instruction", instruction, insE);
    chk("fimDoArquivo", fimDoArquivo, !hitE);
  endtask

  task automatic cycle(input bit ls, input bit bv, input byte unsigned bd, input bit le,
                       input logic [31:0] addr);
    load_start = ls; byte_valid = bv; byte_data = bd; load_end = le; readAddress = addr;
    #1;
    chk("byte_ready", byte_ready, mst == 1 && q.size() < 4 * D);
    hitE = mst == 2 && (addr >> 2) < 32'(wcount());
    insE = hitE ? wordAt(int'(addr >> 2)) : 0;
    if (mst != 1 && ls) begin
      mst = 1; q.delete(); mov = 0;
    end else if (mst == 1) begin
      if (bv) begin
        if (q.size() < 4 * D) q.push_back(bd);
        else mov = 1;
      end
      if (le) mst = 2;
    end
    @(posedge clk); #1;
    checkAll();
  endtask

  task automatic resetCheck(input string tag);
    chk({tag, " loading"}, loading, 0);
    chk({tag, " load_done"}, load_done, 0);
    chk({tag, " word_count"}, word_count, 0);
    chk({tag, " overflow"}, overflow, 0);
    chk({tag, " byte_ready"}, byte_ready, 0);
    chk({tag, " instruction"}, instruction, 0);
    chk({tag, " fimDoArquivo"}, fimDoArquivo, 1);
  endtask

  task automatic asyncReset(input string tag);
    load_start = 0; byte_valid = 0; load_end = 0; readAddress = 0;
    #2 reset = 1;
    #1 resetCheck(tag);
    mst = 0; q.delete(); mov = 0; hitE = 0; insE = 0;
    @(posedge clk); #1 reset = 0;
  endtask

  typedef struct {
    bit ls, bv; byte unsigned bd; bit le; logic [31:0] addr;
    int ewc; logic [31:0] ein; bit efim, eld;
  } vec_t;
  vec_t vecs[$];

  initial begin
    vecs.push_back(vec_t'{1, 0, 8'h00, 0, 8, 0, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 8'h13, 0, 8, 0, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 8'h00, 0, 8, 0, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 8'h00, 0, 8, 0, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 8'h00, 0, 8, 1, 32'h0, 1, 0});
    vecs.push_back(vec_t'{1, 0, 8'h00, 0, 8, 1, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 8'h93, 0, 8, 1, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 8'h00, 0, 8, 1, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 8'h10, 0, 8, 1, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 8'h00, 0, 8, 2, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 8'h00, 1, 0, 2, 32'h0, 1, 1});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 0, 2, 32'h0000_0013, 0, 1});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 4, 2, 32'h0010_0093, 0, 1});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 8, 2, 32'h0, 1, 1});
    vecs.push_back(vec_t'{1, 0, 8'h00, 0, 8, 0, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 8'hAA, 0, 8, 0, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 8'hBB, 0, 8, 0, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 8'h00, 1, 8, 1, 32'h0, 1, 1});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 0, 1, 32'h0000_BBAA, 0, 1});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 4, 1, 32'h0, 1, 1});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 2, 1, 32'h0000_BBAA, 0, 1});
    vecs.push_back(vec_t'{1, 0, 8'h00, 0, 8, 0, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 8'h01, 0, 8, 0, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 8'h02, 0, 8, 0, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 8'h03, 0, 8, 0, 32'h0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 8'h04, 1, 8, 1, 32'h0, 1, 1});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 0, 1, 32'h0403_0201, 0, 1});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 4, 1, 32'h0, 1, 1});

    @(posedge clk); #1;
    resetCheck("reset");
    reset = 0;

    foreach (vecs[i]) begin
      cycle(vecs[i].ls, vecs[i].bv, vecs[i].bd, vecs[i].le, vecs[i].addr);
      chk($sformatf("vec%0d word_count", i), word_count, vecs[i].ewc);
      chk($sformatf("vec%0d instruction", i), instruction, vecs[i].ein);
      chk($sformatf("vec%0d fimDoArquivo", i), fimDoArquivo, vecs[i].efim);
      chk($sformatf("vec%0d load_done", i), load_done, vecs[i].eld);
    end

    // overflow: 20 bytes into a 4-word memory
    cycle(1, 0, 0, 0, 8);
    for (int i = 0; i < 20; i++) begin
      if (i == 16) chk("ovf ready drop", byte_ready, 0);
      cycle(0, 1, byte'(i), 0, 8);
    end
    chk("ovf overflow", overflow, 1);
    chk("ovf word_count", word_count, 4);
    cycle(0, 0, 0, 1, 8);
    chk("ovf sticky in DONE", overflow, 1);
    cycle(0, 0, 0, 0, 12);
    chk("ovf fetch 12", instruction, 32'h0F0E_0D0C);
    cycle(0, 0, 0, 0, 16);
    chk("ovf fetch 16 fim", fimDoArquivo, 1);
    cycle(1, 0, 0, 0, 8);
    chk("ovf cleared by load_start", overflow, 0);

    // reset mid-load after 6 bytes, then a fresh 4-byte load
    for (int i = 0; i < 6; i++) cycle(0, 1, byte'(8'hC0 + i), 0, 8);
    asyncReset("midload");
    cycle(0, 0, 0, 0, 0);
    chk("post reset fetch 0 fim", fimDoArquivo, 1);
    cycle(1, 0, 0, 0, 8);
    for (int i = 0; i < 4; i++) cycle(0, 1, byte'(8'h51 + i), 0, 8);
    cycle(0, 0, 0, 1, 8);
    chk("reload word_count", word_count, 1);
    cycle(0, 0, 0, 0, 0);
    chk("reload data", instruction, 32'h5453_5251);

    // random traffic with backpressure and stray control pulses
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 19));
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, byte'($urandom),
            $urandom_range(0, 11) == 0, a);
    end

    // reset while a fetch is returning a live word
    cycle(1, 0, 0, 0, 8);
    for (int i = 0; i < 4; i++) cycle(0, 1, byte'(8'h11 * (i + 1)), 0, 8);
    cycle(0, 0, 0, 1, 8);
    cycle(0, 0, 0, 0, 0);
    chk("live fetch", instruction, 32'h4433_2211);
    asyncReset("live");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write side of the instruction memory: receives a program as a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words.
- Stores the words in an internal word-addressed RAM.
- Serves the CPU fetch port: byte address in, instruction word out, with an end-of-program flag.
- Sits between the test or boot host and the fetch stage. It replaces file-based program loading with a synthesizable load path.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words stored. Must be a power of two, at least 4.
- CNT_W, $clog2(DEPTH_WORDS)+1, width of word_count. Derived; do not override.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_start  input  1  one-cycle pulse that begins a new load. Honoured only in IDLE or DONE.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  program byte; little-endian within each word.
- byte_ready  output  1  loader accepts a byte this cycle.
- load_end  input  1  one-cycle pulse marking end of program. Honoured only in LOAD.
- loading  output  1  high while in LOAD.
- load_done  output  1  high while in DONE.
- word_count  output  CNT_W  number of words written in the current or last load.
- overflow  output  1  sticky; a byte was offered while the memory was full.
- readAddress  input  32  byte address of the fetch; bits [1:0] are ignored.
- instruction  output  32  fetched word, registered.
- fimDoArquivo  output  1  registered; fetch is outside the loaded program.

Behaviour:
- Reset (asynchronous, any state, including mid-load) sets:
  - state to IDLE
  - byte_ready, loading, load_done, overflow to 0
  - word_count to 0; byte index to 0; pack buffer to 0
  - instruction to 0; fimDoArquivo to 1
- RAM contents are not cleared. Stale data is unreachable because word_count is 0.
- FSM states: IDLE, LOAD, DONE.
  - IDLE to LOAD on load_start.
  - LOAD to DONE on load_end.
  - DONE to LOAD on load_start.
  - load_start while in LOAD is ignored. load_end outside LOAD is ignored.
- Entering LOAD clears word_count, byte index, pack buffer and overflow. This happens on the edge where load_start is sampled.
- byte_ready = (state==LOAD) && (word_count < DEPTH_WORDS). It is combinational from registered state.
- Byte accept (byte_valid && byte_ready):
  - Byte goes into lane byte_idx of the pack buffer (lane 0 = bits [7:0]).
  - byte_idx increments modulo 4.
  - On the 4th byte, the completed word is written to RAM[word_count] on that same edge, word_count increments, and the buffer clears.
- Full condition: byte_valid in LOAD while word_count==DEPTH_WORDS sets overflow (sticky until the next load_start or reset). The byte is dropped.
- load_end in LOAD:
  - If byte_idx != 0, the partial word is zero-padded in the upper lanes, written to RAM[word_count], and word_count increments. If the memory is already full, no write occurs and overflow is set.
  - byte_idx resets to 0. Transition to DONE.
- Simultaneous byte accept and load_end: the byte is accepted first, then the flush rule applies to the resulting buffer. For example, the 4th byte with load_end writes one word with no extra padded word.
- Fetch port: one-cycle latency, registered on every clk edge.
  - Word index widx = readAddress[$clog2(DEPTH_WORDS)+1:2].
  - Upper address bits above the RAM range make the fetch out-of-range.
  - If state==DONE, widx < word_count and the upper bits are zero: instruction <= RAM[widx] and fimDoArquivo <= 0.
  - Otherwise: instruction <= 0 and fimDoArquivo <= 1. This includes IDLE and LOAD.
- Arithmetic: word_count saturates at DEPTH_WORDS and never wraps. byte_idx is 2 bits and wraps.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN = 32 and INSTR_BYTES = 4
  - the loader state enum (IDLE, LOAD, DONE)
  - NOP_INSTR = 32'h0000_0013, reserved for later use; the fetch currently returns 0 out of range
- One sub-module is natural: imem_ram. It is a single-port-write, single-port-read synchronous RAM (DEPTH_WORDS x 32) with registered read. The loader FSM and packer stay in imem_loader.

Test Plan:
- Basic load: load_start, then bytes 13 00 00 00 93 00 10 00, then load_end → word_count=2. readAddress 0 returns 32'h00000013, readAddress 4 returns 32'h00100093, fimDoArquivo=0, each one cycle after the address.
- Partial flush: load_start, bytes AA BB, then load_end → word_count=1. Fetch at 0 returns 32'h0000BBAA. Fetch at 4 returns 0 with fimDoArquivo=1. Fetch at 2 returns 32'h0000BBAA (low bits ignored).
- Overflow with DEPTH_WORDS=4: stream 20 bytes → byte_ready drops after byte 16, overflow=1, word_count=4. Fetch at 12 returns word 3; fetch at 16 gives fimDoArquivo=1.
- Simultaneous event: 4th byte accepted in the same cycle as load_end → exactly one word written, word_count=1, load_done=1 next cycle.
- Reset mid-load: assert reset after 6 bytes → all outputs at reset values immediately (asynchronous), fimDoArquivo=1 for fetch at 0. A new load of 4 bytes then gives word_count=1 with correct data.
- Backpressure and state gating: byte_valid toggling 0/1 during LOAD → only cycles with valid and ready are packed. Fetches during LOAD return 0 with fimDoArquivo=1. load_start during LOAD leaves word_count unchanged.
